// File: rtl/output_pkg.sv
// Shared widths and FSM state encoding for the output packer.
package output_pkg;
    localparam int DATA_W = 8;
    localparam int BUS_W  = 128;
    localparam int ADDR_W = 16;
    localparam int LANES  = BUS_W / DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/output_packer.sv
// Packs equalized pixels into BUS_W-wide memory words at consecutive word addresses.
// Optional feature macro OUTPUT_PACKER_FLUSH_EN: write the zero-padded final partial word.
module output_packer
    import output_pkg::*;
#(
    parameter int DATA_W = output_pkg::DATA_W,
    parameter int BUS_W  = output_pkg::BUS_W,
    parameter int ADDR_W = output_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              FrameStart,
    input  logic [ADDR_W-1:0] BaseAddress,
    input  logic [15:0]       PixelCount,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              StartIn,
    output logic [BUS_W-1:0]  WriteBus,
    output logic [ADDR_W-1:0] WriteAddress,
    output logic              WriteEnable,
    output logic              Busy,
    output logic              FrameDone
);

    localparam int LANES = BUS_W / DATA_W;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

`ifdef OUTPUT_PACKER_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    state_t            state_q,    state_d;
    logic [BUS_W-1:0]  lane_q,     lane_d;
    logic [IDX_W-1:0]  lane_idx_q, lane_idx_d;
    logic [15:0]       pix_cnt_q,  pix_cnt_d;
    logic [15:0]       pix_tot_q,  pix_tot_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [BUS_W-1:0]  wr_bus_q,   wr_bus_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic              wr_en_q,    wr_en_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    logic [BUS_W-1:0]  lane_ins_s;
    logic [15:0]       pix_next_s;
    logic              word_full_s;
    logic              last_pix_s;

    // Next-state logic: frame setup/abort, pixel insertion, word emission
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        lane_idx_d = lane_idx_q;
        pix_cnt_d  = pix_cnt_q;
        pix_tot_d  = pix_tot_q;
        addr_d     = addr_q;
        wr_bus_d   = wr_bus_q;
        wr_addr_d  = wr_addr_q;
        wr_en_d    = 1'b0;
        done_d     = 1'b0;

        lane_ins_s = lane_q;
        lane_ins_s[lane_idx_q*DATA_W +: DATA_W] = DataIn;
        pix_next_s  = pix_cnt_q + 16'd1;
        word_full_s = (lane_idx_q == LAST_LANE);
        last_pix_s  = (pix_next_s == pix_tot_q);

        // FrameStart in any state (including mid-frame abort) discards the partial word
        if (FrameStart) begin
            lane_d     = '0;
            lane_idx_d = '0;
            pix_cnt_d  = 16'd0;
            pix_tot_d  = PixelCount;
            addr_d     = BaseAddress;
            if (PixelCount == 16'd0) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (StartIn) begin
                        pix_cnt_d = pix_next_s;
                        if (word_full_s || (last_pix_s && FLUSH_EN)) begin
                            wr_en_d    = 1'b1;
                            wr_bus_d   = lane_ins_s;
                            wr_addr_d  = addr_q;
                            addr_d     = addr_q + ADDR_W'(1);
                            lane_d     = '0;
                            lane_idx_d = '0;
                        end else begin
                            lane_d     = lane_ins_s;
                            lane_idx_d = lane_idx_q + IDX_W'(1);
                        end
                        if (last_pix_s) begin
                            state_d    = DONE;
                            done_d     = 1'b1;
                            lane_d     = '0;
                            lane_idx_d = '0;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                IDLE:    state_d = IDLE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == RUN);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            lane_idx_q <= '0;
            pix_cnt_q  <= 16'd0;
            pix_tot_q  <= 16'd0;
            addr_q     <= '0;
            wr_bus_q   <= '0;
            wr_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            lane_idx_q <= lane_idx_d;
            pix_cnt_q  <= pix_cnt_d;
            pix_tot_q  <= pix_tot_d;
            addr_q     <= addr_d;
            wr_bus_q   <= wr_bus_d;
            wr_addr_q  <= wr_addr_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign WriteBus     = wr_bus_q;
    assign WriteAddress = wr_addr_q;
    assign WriteEnable  = wr_en_q;
    assign Busy         = busy_q;
    assign FrameDone    = done_q;

endmodule

// File: tb/tb_output_packer.sv
// Directed self-checking bench for output_packer; follows OUTPUT_PACKER_FLUSH_EN if defined.
module tb_output_packer;

    logic         clock;
    logic         reset_n;
    logic         FrameStart;
    logic [15:0]  BaseAddress;
    logic [15:0]  PixelCount;
    logic [7:0]   DataIn;
    logic         StartIn;
    logic [127:0] WriteBus;
    logic [15:0]  WriteAddress;
    logic         WriteEnable;
    logic         Busy;
    logic         FrameDone;

    output_packer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .FrameStart   (FrameStart),
        .BaseAddress  (BaseAddress),
        .PixelCount   (PixelCount),
        .DataIn       (DataIn),
        .StartIn      (StartIn),
        .WriteBus     (WriteBus),
        .WriteAddress (WriteAddress),
        .WriteEnable  (WriteEnable),
        .Busy         (Busy),
        .FrameDone    (FrameDone)
    );

    typedef struct {
        logic [127:0] bus;
        logic [15:0]  addr;
        int           edge_n;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    int  cyc;
    int  last_acc;
    int  errors;
    int  checks;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Writes and FrameDone pulses are logged at the falling edge with the edge number that produced them
    always @(negedge clock) begin
        if (reset_n && WriteEnable) wq.push_back('{WriteBus, WriteAddress, cyc});
        if (reset_n && FrameDone) dq.push_back(cyc);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] wbus(input int i);
        return (i < wq.size()) ? wq[i].bus : 128'hx;
    endfunction

    function automatic logic [15:0] waddr(input int i);
        return (i < wq.size()) ? wq[i].addr : 16'hx;
    endfunction

    function automatic int wedge(input int i);
        return (i < wq.size()) ? wq[i].edge_n : -1;
    endfunction

    function automatic int dedge(input int i);
        return (i < dq.size()) ? dq[i] : -2;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame(input logic [15:0] base, input logic [15:0] cnt);
        FrameStart  = 1'b1;
        BaseAddress = base;
        PixelCount  = cnt;
        step();
        FrameStart  = 1'b0;
        last_acc    = cyc;
    endtask

    task automatic pixel(input logic [7:0] d);
        DataIn  = d;
        StartIn = 1'b1;
        step();
        StartIn  = 1'b0;
        last_acc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_logs();
        wq.delete();
        dq.delete();
    endtask

    initial begin
        logic [127:0] exp_w;
        int           st_edge;
        cyc = 0; errors = 0; checks = 0; last_acc = 0;
        reset_n = 1'b0; FrameStart = 1'b0; BaseAddress = 16'h0;
        PixelCount = 16'h0; DataIn = 8'h0; StartIn = 1'b0;
        #12;
        check("rst_bus",  WriteBus, 128'h0);
        check("rst_addr", {112'h0, WriteAddress}, 128'h0);
        check("rst_ctl",  {125'h0, WriteEnable, Busy, FrameDone}, 128'h0);
        reset_n = 1'b1;
        idle(2);

        // Two full words, back to back
        clear_logs();
        start_frame(16'h0010, 16'd32);
        check("a_busy", {127'h0, Busy}, 128'h1);
        for (int i = 0; i < 32; i++) pixel(8'(i));
        idle(3);
        check("a_nwr",   128'(wq.size()), 128'd2);
        check("a_addr0", {112'h0, waddr(0)}, 128'h0010);
        check("a_bus0",  wbus(0), 128'h0F0E0D0C0B0A09080706050403020100);
        check("a_addr1", {112'h0, waddr(1)}, 128'h0011);
        check("a_bus1",  wbus(1), 128'h1F1E1D1C1B1A19181716151413121110);
        check("a_wr1_at_last", 128'(wedge(1)), 128'(last_acc));
        check("a_ndone", 128'(dq.size()), 128'd1);
        check("a_done_with_wr", 128'(dedge(0)), 128'(wedge(1)));
        check("a_busy_end", {127'h0, Busy}, 128'h0);

        // StartIn ignored in DONE
        clear_logs();
        pixel(8'h55);
        idle(2);
        check("done_ignore", 128'(wq.size() + dq.size()), 128'd0);

        // Gapped input, one word
        clear_logs();
        start_frame(16'h0020, 16'd16);
        exp_w = 128'h0;
        for (int i = 0; i < 16; i++) begin
            pixel(8'(8'hA0 + i));
            exp_w[i*8 +: 8] = 8'(8'hA0 + i);
            if (i != 15) idle(1);
        end
        idle(3);
        check("b_nwr",  128'(wq.size()), 128'd1);
        check("b_bus",  wbus(0), exp_w);
        check("b_addr", {112'h0, waddr(0)}, 128'h0020);
        check("b_edge", 128'(wedge(0)), 128'(last_acc));

        // Address wrap
        clear_logs();
        start_frame(16'hFFFF, 16'd48);
        for (int i = 0; i < 48; i++) pixel(8'(i));
        idle(3);
        check("c_nwr",   128'(wq.size()), 128'd3);
        check("c_addr0", {112'h0, waddr(0)}, 128'hFFFF);
        check("c_addr1", {112'h0, waddr(1)}, 128'h0000);
        check("c_addr2", {112'h0, waddr(2)}, 128'h0001);

        // Partial final word
        clear_logs();
        start_frame(16'h0100, 16'd20);
        for (int i = 0; i < 20; i++) pixel(8'(i));
        idle(3);
        check("d_bus0", wbus(0), 128'h0F0E0D0C0B0A09080706050403020100);
        check("d_done_at_last", 128'(dedge(0)), 128'(last_acc));
`ifdef OUTPUT_PACKER_FLUSH_EN
        check("d_nwr",   128'(wq.size()), 128'd2);
        check("d_bus1",  wbus(1), 128'h00000000000000000000000013121110);
        check("d_addr1", {112'h0, waddr(1)}, 128'h0101);
        check("d_wr1_edge", 128'(wedge(1)), 128'(last_acc));
`else
        check("d_nwr",   128'(wq.size()), 128'd1);
`endif

        // Abort after 5 pixels; restart pixel collides with FrameStart and is dropped
        clear_logs();
        start_frame(16'h0200, 16'd16);
        for (int i = 0; i < 5; i++) pixel(8'hEE);
        StartIn = 1'b1; DataIn = 8'hFF;
        start_frame(16'h0300, 16'd16);
        StartIn = 1'b0;
        exp_w = 128'h0;
        for (int i = 0; i < 16; i++) begin
            pixel(8'(8'h40 + i));
            exp_w[i*8 +: 8] = 8'(8'h40 + i);
        end
        idle(3);
        check("e_nwr",  128'(wq.size()), 128'd1);
        check("e_bus",  wbus(0), exp_w);
        check("e_addr", {112'h0, waddr(0)}, 128'h0300);
        check("e_ndone", 128'(dq.size()), 128'd1);

        // Zero-length frame
        clear_logs();
        start_frame(16'h0500, 16'd0);
        st_edge = cyc;
        idle(3);
        check("z_nwr",  128'(wq.size()), 128'd0);
        check("z_done", 128'(dedge(0)), 128'(st_edge));

        // Reset mid-word
        clear_logs();
        start_frame(16'h0400, 16'd16);
        for (int i = 0; i < 7; i++) pixel(8'(i + 1));
        #2;
        reset_n = 1'b0;
        #1;
        check("r_bus",  WriteBus, 128'h0);
        check("r_addr", {112'h0, WriteAddress}, 128'h0);
        check("r_ctl",  {125'h0, WriteEnable, Busy, FrameDone}, 128'h0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 9; i++) pixel(8'(i + 8));
        idle(3);
        check("r_nwr",  128'(wq.size() + dq.size()), 128'd0);
        check("r_busy", {127'h0, Busy}, 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_packer.md
OUTPUT_PACKER -- requirements
Module: output_packer

Interface
REQ-001 Parameter DATA_W, default 8, pixel width in bits.
REQ-002 Parameter BUS_W, default 128, write-bus width; LANES = BUS_W/DATA_W = 16.
REQ-003 Parameter ADDR_W, default 16, write-address width.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 FrameStart  input  1  one-cycle pulse; loads BaseAddress and PixelCount, clears counters.
REQ-007 BaseAddress  input  ADDR_W  word address of the first output word; sampled on FrameStart.
REQ-008 PixelCount  input  16  pixels in the frame; sampled on FrameStart.
REQ-009 DataIn  input  DATA_W  equalized pixel from the CDF lookup stage.
REQ-010 StartIn  input  1  DataIn valid this cycle; one pixel per high cycle.
REQ-011 WriteBus  output  BUS_W  packed output word.
REQ-012 WriteAddress  output  ADDR_W  output memory word address.
REQ-013 WriteEnable  output  1  WriteBus/WriteAddress valid this cycle; the memory always accepts.
REQ-014 Busy  output  1  high in RUN.
REQ-015 FrameDone  output  1  one-cycle pulse at frame end.

Function
REQ-016 FSM states: IDLE, RUN, DONE.
- IDLE->RUN on FrameStart with PixelCount>0.
- RUN->DONE when the PixelCount-th pixel is accepted.
- DONE->RUN on FrameStart.
- FrameStart with PixelCount==0 stays in or enters DONE and pulses FrameDone the next cycle, with no write.
REQ-017 A pixel is accepted at a rising edge where state==RUN and StartIn==1; StartIn in IDLE or DONE is ignored.
REQ-018 The k-th accepted pixel of a word (k=0..15) occupies WriteBus[8k+7:8k]; the first pixel is in lane 0.
REQ-019 When lane 15 is captured at edge N, WriteBus, WriteAddress and WriteEnable=1 are registered at edge N, so the write is visible for exactly the cycle after edge N.
REQ-020 Packing never stalls: a pixel accepted at edge N+1 goes into lane 0 of the next word.
REQ-021 Word j of a frame is written to BaseAddress+j modulo 2^ADDR_W; 16'hFFFF wraps to 16'h0000.
REQ-022 The internal pixel counter is 16 bits; the frame ends when it equals PixelCount.
REQ-023 FrameDone is registered at the same edge as the final word's WriteEnable; if no final write occurs, it is registered at the edge that accepts the last pixel.
REQ-024 A FrameStart during RUN aborts the frame:
- the partial word is discarded with no write;
- BaseAddress and PixelCount are reloaded;
- the counter is cleared;
- the FSM stays in RUN.
REQ-025 FrameStart and StartIn high on the same edge: FrameStart wins and the pixel is dropped.
REQ-026 WriteEnable is low on every cycle not named in REQ-019 and REQ-028; WriteBus and WriteAddress hold their last values when WriteEnable is low.

Reset
REQ-027 On reset_n low, asynchronously:
- state=IDLE;
- WriteBus=0, WriteAddress=0;
- WriteEnable=0, Busy=0, FrameDone=0;
- lane register and counters cleared.
A reset mid-frame discards all pending data, and no write follows the release of reset.

Configuration
REQ-028 With OUTPUT_PACKER_FLUSH_EN defined and PixelCount not a multiple of 16, the final partial word is written at the last pixel's edge, with unfilled lanes set to zero.
REQ-029 Without OUTPUT_PACKER_FLUSH_EN, the final partial word is discarded and FrameDone still pulses per REQ-023.

Structure
REQ-030 Package output_pkg holds DATA_W, BUS_W, ADDR_W, LANES and the FSM state enum (IDLE, RUN, DONE).
REQ-031 The block is a single module with no sub-module; the lane register, lane index, pixel counter, address counter and FSM are all in output_packer.

Verification
REQ-032 FrameStart, BaseAddress=0x0010, PixelCount=32, pixels 0x00..0x1F back-to-back:
- two writes, to 0x0010 and 0x0011;
- first word 0x0F0E..0100 (lane 0 = 0x00);
- FrameDone coincident with the second write.
REQ-033 PixelCount=16 with StartIn gaps (high every other cycle): one write, one cycle after the 16th accepted pixel, with correct lane order.
REQ-034 BaseAddress=0xFFFF, PixelCount=48: writes to 0xFFFF, 0x0000, 0x0001.
REQ-035 PixelCount=20:
- with FLUSH_EN: second write has lanes 0-3 = data and lanes 4-15 = 0;
- without FLUSH_EN: one write only, and FrameDone pulses at the 20th pixel's edge.
REQ-036 Abort and reset:
- FrameStart after 5 pixels, new PixelCount=16: first write contains only the new frame's pixels;
- reset_n low mid-word: all outputs 0, no write after release.
